// File: rtl/atcaxi2tluh500_arb_rr_pkg.sv
// Shared configuration for the atcaxi2tluh500 round-robin arbiter.
// Holds the FSM state encodings used by the arbiter top.
package atcaxi2tluh500_arb_rr_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

endpackage

// File: rtl/atcaxi2tluh500_arb_rr_fp.sv
// Fixed-priority one-hot picker: the lowest set request bit wins.
module atcaxi2tluh500_arb_fp #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Two's-complement trick isolates the least significant set bit.
  assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/atcaxi2tluh500_arb_rr.sv
// Round-robin arbiter with burst locking: a granted requester keeps the
// downstream channel until its last beat transfers. Data path is combinational.
module atcaxi2tluh500_arb_rr
  import atcaxi2tluh500_arb_rr_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32,
  localparam int IDW = $clog2(N)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [N-1:0]      req_valid,
  input  logic [N-1:0]      req_last,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [DW-1:0]     out_data,
  input  logic              out_ready,
  output logic [N-1:0]      grant,
  output logic [IDW-1:0]    grant_id
);

  function automatic logic [IDW-1:0] oh2idx(input logic [N-1:0] oh);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDW'(i);
    end
    return idx;
  endfunction

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] x);
    return (x == IDW'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  logic           state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;

  logic [N-1:0]   ptr_mask;
  logic [N-1:0]   masked_oh;
  logic [N-1:0]   full_oh;
  logic [N-1:0]   win_oh;
  logic [IDW-1:0] win_id;
  logic           xfer_last;
  logic [DW-1:0]  lane_data [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign ptr_mask[gi]  = (ptr_q <= IDW'(gi));
      assign lane_data[gi] = req_data[gi*DW +: DW] & {DW{grant[gi]}};
    end
  endgenerate

  atcaxi2tluh500_arb_fp #(.N(N)) u_fp_masked (
    .req_i (req_valid & ptr_mask),
    .gnt_o (masked_oh)
  );

  atcaxi2tluh500_arb_fp #(.N(N)) u_fp_full (
    .req_i (req_valid),
    .gnt_o (full_oh)
  );

  // Fall back to the unmasked pick only when nothing at or above ptr is valid.
  assign win_oh = (|masked_oh) ? masked_oh : full_oh;
  assign win_id = oh2idx(win_oh);

  always_comb begin
    grant = '0;
    if (state_q == ST_LOCK) begin
      if (req_valid[owner_q]) grant = N'(1) << owner_q;
    end else begin
      grant = win_oh;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data = out_data | lane_data[i];
    end
  end

  assign out_valid = |grant;
  assign out_last  = |(grant & req_last);
  assign req_ready = grant & {N{out_ready}};
  assign grant_id  = oh2idx(grant);
  assign xfer_last = out_valid & out_ready & out_last;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (state_q == ST_IDLE) begin
      if (out_valid) begin
        if (xfer_last) begin
          ptr_d = next_idx(win_id);
        end else begin
          state_d = ST_LOCK;
          owner_d = win_id;
        end
      end
    end else if (xfer_last) begin
      state_d = ST_IDLE;
      ptr_d   = next_idx(owner_q);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_atcaxi2tluh500_arb_rr.sv
// Bench for the round-robin burst arbiter: directed scenarios plus random
// traffic, checked against a circular-search reference model.
module tb_atcaxi2tluh500_arb_rr;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic              aclk;
  logic              areset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic              out_last;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic [N-1:0]      grant;
  logic [IDW-1:0]    grant_id;

  int tests;
  int fails;

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  // Expected values for the current cycle
  int             e_id;
  logic [N-1:0]   e_grant;
  logic           e_valid;
  logic           e_last;

  atcaxi2tluh500_arb_rr #(.N(N), .DW(DW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
  endtask

  task automatic check_now(input string tag);
    logic [DW-1:0] e_data;
    e_grant = '0;
    e_id    = 0;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (req_valid[idx]) begin
          e_grant = N'(1) << idx;
          e_id    = idx;
          break;
        end
      end
    end else if (req_valid[m_owner]) begin
      e_grant = N'(1) << m_owner;
      e_id    = m_owner;
    end
    e_valid = (e_grant != 0);
    e_last  = e_valid ? req_last[e_id] : 1'b0;
    e_data  = e_valid ? req_data[e_id*DW +: DW] : '0;
    chk({tag, ".grant"},     64'(grant),     64'(e_grant));
    chk({tag, ".grant_id"},  64'(grant_id),  64'(e_id));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(e_grant & {N{out_ready}}));
    chk({tag, ".out_data"},  64'(out_data),  64'(e_data));
    if (e_valid) chk({tag, ".out_last"}, 64'(out_last), 64'(e_last));
  endtask

  // One clock cycle: check combinational outputs, then advance model at the edge.
  task automatic step(input string tag, input int exp_id);
    bit rdy;
    #1;
    check_now(tag);
    if (exp_id >= 0) chk({tag, ".dir_id"}, 64'(grant_id), 64'(exp_id));
    rdy = out_ready;
    @(posedge aclk);
    if (e_valid && rdy && e_last) begin
      m_locked = 0;
      m_ptr    = (e_id + 1) % N;
    end else if (e_valid && !m_locked) begin
      m_locked = 1;
      m_owner  = e_id;
    end
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    areset = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();
    #3;
    check_now("reset");
    chk("reset.grant_zero", 64'(grant), 64'(0));
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Idle with no requests
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b1;
      set_data();
      step("idle", 0);
    end

    // All requesters single-beat: rotation 0,1,2,3,0
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      set_data();
      step("rr", c % N);
    end

    // ptr=1: requester 2 bursts 4 beats while requester 0 waits
    req_valid = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      req_last = (b == 3) ? 4'b0101 : 4'b0001;
      set_data();
      step("burst", 2);
    end
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    step("burst_wrap", 0);

    // ptr=1: requester 1 stalled, requester 0 arrives but cannot preempt
    req_valid = 4'b0010;
    req_last  = 4'b0011;
    out_ready = 1'b0;
    step("stall0", 1);
    req_valid = 4'b0011;
    step("stall1", 1);
    chk("stall1.onehot", 64'(grant), 64'(4'b0010));
    step("stall2", 1);
    out_ready = 1'b1;
    step("stall_xfer", 1);
    step("stall_after", 0);

    // Move ptr to 3, then alternate requesters 3 and 0
    req_valid = 4'b1000;
    req_last  = 4'b1111;
    step("to_ptr3", 3);
    req_valid = 4'b0100;
    step("ptr_adv", 2);
    req_valid = 4'b1001;
    step("wrap0", 3);
    step("wrap1", 0);
    step("wrap2", 3);

    // Reset in the middle of a locked burst on requester 2
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    step("lock_b1", 2);
    #2;
    areset = 1'b1;
    model_reset();
    #1;
    check_now("mid_reset");
    @(negedge aclk);
    areset = 1'b0;
    #1;
    req_valid = 4'b0110;
    req_last  = 4'b0110;
    set_data();
    step("post_reset", 1);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_last  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      set_data();
      step("rand", -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/atcaxi2tluh500_arb_rr.md
ATCAXI2TLUH500_ARB_RR -- requirements
Module: atcaxi2tluh500_arb_rr

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one downstream channel; legal range 2..16.
REQ-002 Parameter DW, default 32: payload width per requester.
REQ-003 Localparam IDW = clog2(N): width of the encoded grant index.
REQ-004 aclk  input  1: single clock; all state updates on the rising edge.
REQ-005 areset  input  1: reset, asynchronous, active-high.
REQ-006 req_valid  input  N: per-requester beat valid.
REQ-007 req_last  input  N: per-requester last-beat-of-burst flag, qualified by req_valid.
REQ-008 req_data  input  N*DW: per-requester payload; requester i occupies bits [i*DW +: DW].
REQ-009 req_ready  output  N: per-requester accept.
REQ-010 out_valid  output  1: downstream beat valid.
REQ-011 out_last  output  1: downstream last-beat flag.
REQ-012 out_data  output  DW: downstream payload.
REQ-013 out_ready  input  1: downstream accept.
REQ-014 grant  output  N: one-hot current grant, all-zero when nothing is granted.
REQ-015 grant_id  output  IDW: encoded index of the granted requester, 0 when grant is zero.

Function
REQ-016 Beat handshake: a beat transfers when out_valid and out_ready are both 1. req_ready[i] = grant[i] & out_ready.
REQ-017 out_valid = |grant. out_data, out_last = the granted requester's req_data, req_last. out_data = 0 when grant is zero.
REQ-018 Data path is combinational, with zero-cycle latency from input to output; state is held only in the FSM, ptr and owner registers.
REQ-019 FSM states: IDLE (no owner) and LOCK (grant fixed to owner).
REQ-020 In IDLE, the winner is the lowest index i >= ptr with req_valid[i] set; if there is none, the winner is the lowest valid index below ptr (round-robin wrap).
REQ-021 IDLE -> LOCK when out_valid & ~(out_ready & out_last); owner <= winner.
REQ-022 IDLE, transfer with out_last=1: stay in IDLE; ptr <= (winner+1) mod N.
REQ-023 In LOCK, grant = one-hot(owner) while req_valid[owner] is 1. Other requesters are never granted, whatever their priority.
REQ-024 LOCK -> IDLE on a transfer with out_last=1; ptr <= (owner+1) mod N.
REQ-025 A non-last transfer, or out_ready=0, leaves state, owner and ptr unchanged.
REQ-026 If req_valid[owner] drops in LOCK (source protocol violation), grant = 0 and the block stays in LOCK.
REQ-027 ptr wraps from N-1 to 0. With N not a power of two, ptr never holds a value >= N.
REQ-028 With req_valid = 0 in IDLE: out_valid=0, req_ready=0, grant=0, and no state change.
REQ-029 Grant stability: once out_valid is asserted, grant and out_data source are stable until the burst's last beat transfers.

Reset
REQ-030 While areset is high, and at release: state=IDLE, ptr=0, owner=0.
REQ-031 Combinational outputs follow the reset register values. With any req_valid set, the lowest valid index is granted in the first cycle after release.
REQ-032 Reset asserted mid-burst aborts the lock immediately. The partial burst is not resumed or tracked.

Structure
REQ-033 FSM state encodings are localparams in the shared atcaxi2tluh500 config include. No typedefs are required.
REQ-034 Round-robin selection instantiates atcaxi2tluh500_arb_fp twice, both with parameter N:
- first instance on req_valid masked to indices >= ptr;
- second instance on unmasked req_valid;
- the masked result is used when it is non-zero.
REQ-035 One-hot to index encoding is done in a local function, not in a separate module.

Verification
REQ-036 N=4, req_valid=4'b1111, req_last=4'b1111, out_ready=1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 Requester 2 sends a 4-beat burst while requester 0 is continuously valid, out_ready=1 -> grant_id=2 for 4 cycles, then grant_id=0 (ptr=3, requester 3 idle, wrap).
REQ-038 Requester 1 valid, out_ready=0 for 3 cycles, requester 0 raises valid in cycle 2 -> grant stays 4'b0010 until the last beat of requester 1 transfers.
REQ-039 ptr=3, req_valid=4'b1001, single beats -> grant_id 3, then 0, then 3.
REQ-040 areset pulsed during beat 2 of a 4-beat LOCK on requester 2, with req_valid=4'b0110 after release -> state=IDLE, ptr=0, grant_id=1.
REQ-041 req_valid=0 for 5 cycles in IDLE -> out_valid=0, req_ready=0, and ptr unchanged.
